// File: rtl/cdc_clear_seq_responder.sv
// Receiver end of the CDC clear sequence: applies IDLE/ISOLATE/CLEAR/POST_CLEAR phases locally and
// acknowledges each through phase_ready_o. Optional isolate-ack timeout: CDC_CLEAR_SEQ_RESPONDER_TIMEOUT_EN.

package cdc_clear_sync_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISOLATE    = 2'd1,
    CLEAR      = 2'd2,
    POST_CLEAR = 2'd3
  } clear_seq_phase_e;

endpackage

module cdc_clear_seq_responder
  import cdc_clear_sync_pkg::*;
#(
  parameter int unsigned ClearCycles   = 1,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  clear_seq_phase_e phase_i,
  input  logic             phase_valid_i,
  output logic             phase_ready_o,
  output logic             isolate_o,
  input  logic             isolate_ack_i,
  output logic             clear_o,
  output clear_seq_phase_e phase_o,
  output logic             error_o,
  output logic             timeout_o
);

  localparam int unsigned CntW = $clog2(ClearCycles + 1);

  typedef enum logic [2:0] {
    SETTLED    = 3'd0,
    ISO_WAIT   = 3'd1,
    CLEARING   = 3'd2,
    DEISO_WAIT = 3'd3,
    ACK        = 3'd4
  } state_e;

  if (ClearCycles == 0 || TimeoutCycles == 0) begin : g_param_check
    $error("ClearCycles and TimeoutCycles must both be at least 1");
  end

  state_e           state_q, state_d;
  clear_seq_phase_e phase_q, phase_d;
  logic             ready_q, ready_d;
  logic             isolate_q, isolate_d;
  logic             clear_q, clear_d;
  logic             error_q, error_d;
  logic [CntW-1:0]  clr_cnt_q, clr_cnt_d;

  logic             handshake;
  logic             legal_move;
  logic             ack_at_target;

`ifdef CDC_CLEAR_SEQ_RESPONDER_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
  logic [TmoW-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic             timeout_q, timeout_d;
`endif

  // The sequence only ever advances one step around the ring.
  assign legal_move    = (phase_i == clear_seq_phase_e'(phase_q + 2'd1));
  assign handshake     = phase_valid_i & ready_q;
  assign ack_at_target = (state_q == ISO_WAIT) ? isolate_ack_i : ~isolate_ack_i;

  // NOTE: every _d gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    ready_d   = ready_q;
    isolate_d = isolate_q;
    clear_d   = clear_q;
    error_d   = 1'b0;
    clr_cnt_d = clr_cnt_q;
`ifdef CDC_CLEAR_SEQ_RESPONDER_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    timeout_d = timeout_q;
`endif

    unique case (state_q)
      SETTLED: begin
        if (handshake) begin
          ready_d = 1'b0;
          if (!legal_move) begin
            state_d = ACK;
            error_d = (phase_i != phase_q);
          end else begin
            phase_d = phase_i;
            unique case (phase_i)
              ISOLATE: begin
                state_d   = ISO_WAIT;
                isolate_d = 1'b1;
`ifdef CDC_CLEAR_SEQ_RESPONDER_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
              end
              CLEAR: begin
                state_d   = CLEARING;
                clear_d   = 1'b1;
                clr_cnt_d = CntW'(ClearCycles);
              end
              POST_CLEAR: begin
                state_d = ACK;
              end
              IDLE: begin
                state_d   = DEISO_WAIT;
                isolate_d = 1'b0;
`ifdef CDC_CLEAR_SEQ_RESPONDER_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
              end
              default: state_d = ACK;
            endcase
          end
        end
      end

      ISO_WAIT, DEISO_WAIT: begin
        if (ack_at_target) begin
          state_d = SETTLED;
          ready_d = 1'b1;
        end
`ifdef CDC_CLEAR_SEQ_RESPONDER_TIMEOUT_EN
        else if (tmo_cnt_q == TmoW'(TimeoutCycles - 1)) begin
          state_d   = SETTLED;
          ready_d   = 1'b1;
          timeout_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        end
`endif
      end

      CLEARING: begin
        clr_cnt_d = clr_cnt_q - CntW'(1);
        if (clr_cnt_q == CntW'(1)) begin
          state_d = SETTLED;
          ready_d = 1'b1;
          clear_d = 1'b0;
        end
      end

      ACK: begin
        state_d = SETTLED;
        ready_d = 1'b1;
      end

      default: begin
        state_d = SETTLED;
        ready_d = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= SETTLED;
      phase_q   <= IDLE;
      ready_q   <= 1'b1;
      isolate_q <= 1'b0;
      clear_q   <= 1'b0;
      error_q   <= 1'b0;
      clr_cnt_q <= '0;
`ifdef CDC_CLEAR_SEQ_RESPONDER_TIMEOUT_EN
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      ready_q   <= ready_d;
      isolate_q <= isolate_d;
      clear_q   <= clear_d;
      error_q   <= error_d;
      clr_cnt_q <= clr_cnt_d;
`ifdef CDC_CLEAR_SEQ_RESPONDER_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign phase_ready_o = ready_q;
  assign isolate_o     = isolate_q;
  assign clear_o       = clear_q;
  assign phase_o       = phase_q;
  assign error_o       = error_q;

`ifdef CDC_CLEAR_SEQ_RESPONDER_TIMEOUT_EN
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_clear_seq_responder.sv
// Directed bench for cdc_clear_seq_responder (ClearCycles=4, TimeoutCycles=8): cycle-by-cycle
// vector table for the phase walk, plus hand sequences for mid-clear reset and ack timeout.

module tb_cdc_clear_seq_responder;
  import cdc_clear_sync_pkg::*;

  localparam int unsigned ClearCycles   = 4;
  localparam int unsigned TimeoutCycles = 8;

`ifdef CDC_CLEAR_SEQ_RESPONDER_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  typedef struct {
    logic             valid;
    clear_seq_phase_e phase;
    logic             ack;
    logic             exp_ready;
    clear_seq_phase_e exp_phase;
    logic             exp_iso;
    logic             exp_clr;
    logic             exp_err;
    logic             exp_tmo;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  clear_seq_phase_e phase_in = IDLE;
  logic             valid_in = 1'b0;
  logic             ack_in = 1'b0;
  logic             ready_out, iso_out, clr_out, err_out, tmo_out;
  clear_seq_phase_e phase_out;

  int n_checks = 0;
  int n_errors = 0;
  int vec_no   = 0;
  vec_t vecs[$];

  cdc_clear_seq_responder #(
    .ClearCycles  (ClearCycles),
    .TimeoutCycles(TimeoutCycles)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .phase_i      (phase_in),
    .phase_valid_i(valid_in),
    .phase_ready_o(ready_out),
    .isolate_o    (iso_out),
    .isolate_ack_i(ack_in),
    .clear_o      (clr_out),
    .phase_o      (phase_out),
    .error_o      (err_out),
    .timeout_o    (tmo_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic v, input clear_seq_phase_e ph, input logic a,
                     input logic r, input clear_seq_phase_e eph, input logic iso,
                     input logic clr, input logic err, input logic tmo);
    vec_t x;
    x = '{v, ph, a, r, eph, iso, clr, err, tmo};
    vecs.push_back(x);
  endtask

  task automatic check_outputs(input string tag, input logic r, input clear_seq_phase_e eph,
                               input logic iso, input logic clr, input logic err, input logic tmo);
    check({tag, " ready"},   8'(ready_out), 8'(r));
    check({tag, " phase"},   8'(phase_out), 8'(eph));
    check({tag, " isolate"}, 8'(iso_out),   8'(iso));
    check({tag, " clear"},   8'(clr_out),   8'(clr));
    check({tag, " error"},   8'(err_out),   8'(err));
    check({tag, " timeout"}, 8'(tmo_out),   8'(tmo));
  endtask

  // Drive one cycle of inputs, cross the clock edge, then compare the registered outputs.
  task automatic apply(input vec_t x);
    valid_in = x.valid;
    phase_in = x.phase;
    ack_in   = x.ack;
    step();
    vec_no++;
    check_outputs($sformatf("v%0d", vec_no), x.exp_ready, x.exp_phase, x.exp_iso,
                  x.exp_clr, x.exp_err, x.exp_tmo);
  endtask

  initial begin
    // IDLE -> ISOLATE, ack rises at T+3, ready back at T+4
    add(1, ISOLATE, 0,   0, ISOLATE, 1, 0, 0, 0);
    add(0, ISOLATE, 0,   0, ISOLATE, 1, 0, 0, 0);
    add(0, ISOLATE, 0,   0, ISOLATE, 1, 0, 0, 0);
    add(0, ISOLATE, 1,   1, ISOLATE, 1, 0, 0, 0);
    // ISOLATE -> CLEAR, four clear cycles, ready at T+5
    add(1, CLEAR, 1,     0, CLEAR, 1, 1, 0, 0);
    add(0, CLEAR, 1,     0, CLEAR, 1, 1, 0, 0);
    add(0, CLEAR, 1,     0, CLEAR, 1, 1, 0, 0);
    add(0, CLEAR, 1,     0, CLEAR, 1, 1, 0, 0);
    add(0, CLEAR, 1,     1, CLEAR, 1, 0, 0, 0);
    // CLEAR -> POST_CLEAR (ack at T+2), POST_CLEAR -> IDLE with ack dropping at T'+2
    add(1, POST_CLEAR, 1, 0, POST_CLEAR, 1, 0, 0, 0);
    add(0, POST_CLEAR, 1, 1, POST_CLEAR, 1, 0, 0, 0);
    add(1, IDLE, 1,      0, IDLE, 0, 0, 0, 0);
    add(0, IDLE, 1,      0, IDLE, 0, 0, 0, 0);
    add(0, IDLE, 0,      1, IDLE, 0, 0, 0, 0);
    // illegal IDLE -> CLEAR
    add(1, CLEAR, 0,     0, IDLE, 0, 0, 1, 0);
    add(0, CLEAR, 0,     1, IDLE, 0, 0, 0, 0);
    // same-phase no-op
    add(1, IDLE, 0,      0, IDLE, 0, 0, 0, 0);
    add(0, IDLE, 0,      1, IDLE, 0, 0, 0, 0);
    // ack already high on ISOLATE entry: one wait cycle
    add(1, ISOLATE, 1,   0, ISOLATE, 1, 0, 0, 0);
    add(0, ISOLATE, 1,   1, ISOLATE, 1, 0, 0, 0);
    // illegal ISOLATE -> POST_CLEAR, then ISOLATE no-op
    add(1, POST_CLEAR, 1, 0, ISOLATE, 1, 0, 1, 0);
    add(0, POST_CLEAR, 1, 1, ISOLATE, 1, 0, 0, 0);
    add(1, ISOLATE, 1,   0, ISOLATE, 1, 0, 0, 0);
    add(0, ISOLATE, 1,   1, ISOLATE, 1, 0, 0, 0);

    repeat (2) step();
    rst = 1'b0;
    step();
    check_outputs("reset", 1'b1, IDLE, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Async reset in the middle of CLEARING
    apply('{1, CLEAR, 1,  0, CLEAR, 1, 1, 0, 0});
    apply('{0, CLEAR, 1,  0, CLEAR, 1, 1, 0, 0});
    #2 rst = 1'b1;
    #1;
    check_outputs("async_rst", 1'b1, IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    ack_in = 1'b0;
    valid_in = 1'b0;
    phase_in = IDLE;
    step();
    check_outputs("post_rst", 1'b1, IDLE, 1'b0, 1'b0, 1'b0, 1'b0);

    // Fresh sequence after reset runs the full ring
    apply('{1, ISOLATE, 1, 0, ISOLATE, 1, 0, 0, 0});
    apply('{0, ISOLATE, 1, 1, ISOLATE, 1, 0, 0, 0});
    apply('{1, CLEAR, 1,   0, CLEAR, 1, 1, 0, 0});
    for (int i = 0; i < 3; i++) apply('{0, CLEAR, 1, 0, CLEAR, 1, 1, 0, 0});
    apply('{0, CLEAR, 1,   1, CLEAR, 1, 0, 0, 0});
    apply('{1, POST_CLEAR, 1, 0, POST_CLEAR, 1, 0, 0, 0});
    apply('{0, POST_CLEAR, 1, 1, POST_CLEAR, 1, 0, 0, 0});
    apply('{1, IDLE, 0,    0, IDLE, 0, 0, 0, 0});
    apply('{0, IDLE, 0,    1, IDLE, 0, 0, 0, 0});

    // ISOLATE with ack held low: timeout after 8 wait cycles only when the feature is built in
    apply('{1, ISOLATE, 0, 0, ISOLATE, 1, 0, 0, 0});
    for (int i = 0; i < 7; i++) apply('{0, ISOLATE, 0, 0, ISOLATE, 1, 0, 0, 0});
    for (int i = 0; i < 4; i++) apply('{0, ISOLATE, 0, TmoEn, ISOLATE, 1, 0, 0, TmoEn});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
